// File: rtl/mem_pkg.sv
// +--------------------------------------------------------------------+
// | mem_pkg : shared types and constants for the pipeline memory stage |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_H_LO = 4'b0011;
  localparam logic [3:0] BE_H_HI = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
// +--------------------------------------------------------------------+
// | lsu_align : store lane steering, byte enables, load formatting and |
// | alignment / funct3 fault detection.  rev 1.0                       |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_align
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] store_data,
  input  logic [WIDTH-1:0] load_word,
  output logic [WIDTH-1:0] wdata,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] load_data,
  output logic             fault
);

  logic [WIDTH-1:0] w_byte_shift;
  logic [WIDTH-1:0] w_half_shift;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  assign w_byte_shift = load_word >> {addr_lo, 3'b000};
  assign w_half_shift = load_word >> {addr_lo[1], 4'b0000};
  assign w_byte       = w_byte_shift[7:0];
  assign w_half       = w_half_shift[15:0];

  always_comb begin
    wdata     = store_data;
    be        = BE_WORD;
    load_data = '0;
    fault     = 1'b0;
    if (is_store) begin
      // Stores only have B/H/W; any funct3 with bit 2 set is illegal.
      case (funct3)
        F3_B: begin
          be    = BE_B0 << addr_lo;
          wdata = {(WIDTH/8){store_data[7:0]}};
        end
        F3_H: begin
          be    = addr_lo[1] ? BE_H_HI : BE_H_LO;
          wdata = {(WIDTH/16){store_data[15:0]}};
          fault = addr_lo[0];
        end
        F3_W: begin
          be    = BE_WORD;
          fault = |addr_lo;
        end
        default: begin
          be    = BE_NONE;
          fault = 1'b1;
        end
      endcase
    end else begin
      case (funct3)
        F3_B:  load_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
        F3_BU: load_data = {{(WIDTH-8){1'b0}}, w_byte};
        F3_H: begin
          load_data = {{(WIDTH-16){w_half[15]}}, w_half};
          fault     = addr_lo[0];
        end
        F3_HU: begin
          load_data = {{(WIDTH-16){1'b0}}, w_half};
          fault     = addr_lo[0];
        end
        F3_W: begin
          load_data = load_word;
          fault     = |addr_lo;
        end
        default: fault = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// +--------------------------------------------------------------------+
// | mem_stage : pipeline MEM stage with req/ack data port, timeout and |
// | registered MEM/WB bundle.  rev 1.0                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_stage
  import mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             MemtoReg_i,
  input  logic             RegWrite_i,
  input  logic [WIDTH-1:0] ALU_Result_i,
  input  logic [WIDTH-1:0] WriteData_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] PC_i,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             stall,
  output logic             MemtoReg_o,
  output logic             RegWrite_o,
  output logic [WIDTH-1:0] ReadData_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] PC_o,
  output logic             misalign_o,
  output logic             timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             timed_out_q, timed_out_d;

  logic             memtoreg_q, memtoreg_d;
  logic             regwrite_q, regwrite_d;
  logic [WIDTH-1:0] read_data_q, read_data_d;
  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic             timeout_q, timeout_d;

  logic             req_c;
  logic             stall_c;
  logic             mem_op;
  logic             fault;
  logic [WIDTH-1:0] load_data;

  assign mem_op  = MemRead_i | MemWrite_i;
  assign cnt_inc = cnt_q + 1'b1;

  lsu_align #(
    .WIDTH(WIDTH)
  ) u_align (
    .is_store   (MemWrite_i),
    .funct3     (instr_i[14:12]),
    .addr_lo    (ALU_Result_i[1:0]),
    .store_data (WriteData_i),
    .load_word  (mem_rdata),
    .wdata      (mem_wdata),
    .be         (mem_be),
    .load_data  (load_data),
    .fault      (fault)
  );

  assign mem_we   = MemWrite_i;
  assign mem_addr = {ALU_Result_i[WIDTH-1:2], 2'b00};
  assign mem_req  = req_c & reset;
  assign stall    = stall_c & reset;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    timed_out_d  = timed_out_q;
    req_c        = 1'b0;
    stall_c      = 1'b0;
    memtoreg_d   = MemtoReg_i;
    regwrite_d   = RegWrite_i;
    read_data_d  = '0;
    alu_result_d = ALU_Result_i;
    instr_d      = instr_i;
    pc_d         = PC_i;
    misalign_d   = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d       = '0;
        rdata_d     = '0;
        timed_out_d = 1'b0;
        if (mem_op && !fault) begin
          req_c        = 1'b1;
          stall_c      = 1'b1;
          state_d      = ACCESS;
          memtoreg_d   = 1'b0;
          regwrite_d   = 1'b0;
          alu_result_d = '0;
          instr_d      = '0;
          pc_d         = '0;
        end else if (mem_op) begin
          regwrite_d = 1'b0;
          misalign_d = 1'b1;
        end
      end
      ACCESS: begin
        req_c        = 1'b1;
        stall_c      = 1'b1;
        memtoreg_d   = 1'b0;
        regwrite_d   = 1'b0;
        alu_result_d = '0;
        instr_d      = '0;
        pc_d         = '0;
        cnt_d        = cnt_inc;
        if (mem_ack) begin
          // A combined read+write request is a store, so no load data.
          rdata_d = MemWrite_i ? '0 : load_data;
          state_d = DONE;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          timed_out_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        read_data_d = rdata_q;
        regwrite_d  = RegWrite_i & ~timed_out_q;
        timeout_d   = timed_out_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      timed_out_q  <= 1'b0;
      memtoreg_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      instr_q      <= '0;
      pc_q         <= '0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      timed_out_q  <= timed_out_d;
      memtoreg_q   <= memtoreg_d;
      regwrite_q   <= regwrite_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      misalign_q   <= misalign_d;
      timeout_q    <= timeout_d;
    end
  end

  assign MemtoReg_o   = memtoreg_q;
  assign RegWrite_o   = regwrite_q;
  assign ReadData_o   = read_data_q;
  assign ALU_Result_o = alu_result_q;
  assign instr_o      = instr_q;
  assign PC_o         = pc_q;
  assign misalign_o   = misalign_q;
  assign timeout_o    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// +--------------------------------------------------------------------+
// | tb_mem_stage : directed + randomized self-checking bench for       |
// | mem_stage against a behavioural load/store model.  rev 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i;
  logic [31:0] ALU_Result_i, WriteData_i, instr_i, PC_i;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        MemtoReg_o, RegWrite_o;
  logic [31:0] ReadData_o, ALU_Result_o, instr_o, PC_o;
  logic        misalign_o, timeout_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage #(.WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
    .ALU_Result_i(ALU_Result_i), .WriteData_i(WriteData_i),
    .instr_i(instr_i), .PC_i(PC_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
    .ReadData_o(ReadData_o), .ALU_Result_o(ALU_Result_o),
    .instr_o(instr_o), .PC_o(PC_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules, written from the ISA description in plain arithmetic.
  function automatic bit ref_fault(input bit wr, input int f3, input logic [31:0] a);
    int size;
    if (wr) begin
      if (f3 > 2) return 1'b1;
      size = f3;
    end else begin
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
      size = f3 % 4;
    end
    if (size == 1 && (a % 2) != 0) return 1'b1;
    if (size == 2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (8 * (a & 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? b - 32'd256 : b;
      4: return b;
      1: return (h >= 32768) ? h - 32'd65536 : h;
      5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_be(input bit wr, input int f3, input logic [31:0] a);
    if (!wr || f3 == 2) return 32'd15;
    if (f3 == 0) return 32'd1 << (a % 4);
    return 32'd3 << (a & 2);
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] d);
    if (f3 == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Entered and left at posedge+1 with the stage in IDLE.  ack_n = 0 never acks.
  task automatic do_op(input bit rd, input bit wr, input bit m2r, input bit rw, input int f3,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input int ack_n, input logic [31:0] rdata);
    logic [31:0] ins, pc, exp_rd;
    bit flt, to;
    int k;
    ins = ($urandom & 32'hFFFF_8FFF) | (32'(f3) << 12);
    pc  = $urandom & 32'hFFFF_FFFC;
    MemRead_i = rd; MemWrite_i = wr; MemtoReg_i = m2r; RegWrite_i = rw;
    ALU_Result_i = alu; WriteData_i = wd; instr_i = ins; PC_i = pc;
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    flt = (rd || wr) && ref_fault(wr, f3, alu);
    if (!(rd || wr) || flt) begin
      chk("idle_stall", 32'(stall), 0);
      chk("idle_req", 32'(mem_req), 0);
      @(posedge clk); #1;
      chk("pass_regwrite", 32'(RegWrite_o), 32'(rw && !flt));
      chk("pass_memtoreg", 32'(MemtoReg_o), 32'(m2r));
      chk("pass_readdata", ReadData_o, 0);
      chk("pass_alu", ALU_Result_o, alu);
      chk("pass_instr", instr_o, ins);
      chk("pass_pc", PC_o, pc);
      chk("pass_misalign", 32'(misalign_o), 32'(flt));
      chk("pass_timeout", 32'(timeout_o), 0);
      return;
    end
    chk("req_first", 32'(mem_req), 1);
    chk("stall_first", 32'(stall), 1);
    chk("mem_addr", mem_addr, alu & 32'hFFFF_FFFC);
    chk("mem_we", 32'(mem_we), 32'(wr));
    chk("mem_be", 32'(mem_be), ref_be(wr, f3, alu));
    if (wr) chk("mem_wdata", mem_wdata, ref_wdata(f3, wd));
    @(posedge clk); #1;
    chk("bubble_regwrite", 32'(RegWrite_o), 0);
    chk("bubble_alu", ALU_Result_o, 0);
    k = 0; to = 1'b0;
    forever begin
      k++;
      chk("access_req", 32'(mem_req), 1);
      chk("access_stall", 32'(stall), 1);
      mem_ack   = (k == ack_n);
      mem_rdata = (k == ack_n) ? rdata : $urandom;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (k == ack_n) break;
      if (k == TMO) begin to = 1'b1; break; end
    end
    chk("done_req", 32'(mem_req), 0);
    chk("done_stall", 32'(stall), 0);
    // Stray ack in DONE must not disturb the captured data.
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    exp_rd = (wr || to) ? 32'd0 : ref_load(f3, alu, rdata);
    chk("out_readdata", ReadData_o, exp_rd);
    chk("out_regwrite", 32'(RegWrite_o), 32'(rw && !to));
    chk("out_memtoreg", 32'(MemtoReg_o), 32'(m2r));
    chk("out_timeout", 32'(timeout_o), 32'(to));
    chk("out_misalign", 32'(misalign_o), 0);
    chk("out_alu", ALU_Result_o, alu);
    chk("out_instr", instr_o, ins);
    chk("out_pc", PC_o, pc);
  endtask

  task automatic clear_inputs();
    MemRead_i = 0; MemWrite_i = 0; MemtoReg_i = 0; RegWrite_i = 0;
    ALU_Result_i = 0; WriteData_i = 0; instr_i = 0; PC_i = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_regwrite", 32'(RegWrite_o), 0);
    chk("rst_alu", ALU_Result_o, 0);
    chk("rst_pc", PC_o, 0);
    chk("rst_misalign", 32'(misalign_o), 0);
    reset = 1'b1;

    do_op(0, 0, 0, 1, 0, 32'h1234, 32'h0, 0, 32'h0);                  // ADD
    do_op(1, 0, 1, 1, 0, 32'h1003, 32'h0, 3, 32'h80FF_FFFF);          // LB
    do_op(1, 0, 1, 1, 4, 32'h1003, 32'h0, 3, 32'h80FF_FFFF);          // LBU
    chk("lb_literal", ref_load(0, 32'h1003, 32'h80FF_FFFF), 32'hFFFF_FF80);
    do_op(0, 1, 0, 0, 1, 32'h2002, 32'h0000_ABCD, 1, 32'h0);          // SH
    do_op(1, 0, 1, 1, 2, 32'h3002, 32'h0, 1, 32'h0);                  // misaligned LW
    do_op(1, 0, 1, 1, 2, 32'h3000, 32'h0, 0, 32'h0);                  // LW timeout
    do_op(1, 1, 1, 1, 2, 32'h3100, 32'h5555_AAAA, 2, 32'hDEAD_BEEF);  // both -> store
    do_op(0, 1, 0, 0, 5, 32'h3200, 32'h1, 1, 32'h0);                  // illegal store
    do_op(1, 0, 1, 1, 3, 32'h3300, 32'h0, 1, 32'h0);                  // illegal load

    // Reset in the middle of an access.
    MemRead_i = 1; MemtoReg_i = 1; RegWrite_i = 1; ALU_Result_i = 32'h4000;
    instr_i = 32'h0000_2003; PC_i = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    chk("midrst_req", 32'(mem_req), 0);
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_regwrite", 32'(RegWrite_o), 0);
    chk("midrst_alu", ALU_Result_o, 0);
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stray_ack_stall", 32'(stall), 0);
    chk("stray_ack_readdata", ReadData_o, 0);
    do_op(1, 0, 1, 1, 2, 32'h4000, 32'h0, 2, 32'h1357_9BDF);          // LW after reset

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      bit r, w;
      a = $urandom;
      r = 1'($urandom);
      w = 1'($urandom);
      if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC | 32'($urandom_range(0, 3) & (i % 4));
      do_op(r, w, 1'($urandom), 1'($urandom), $urandom_range(0, 7), a, $urandom,
            $urandom_range(0, TMO + 1), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
